imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the processor datapath. It is the next generation of the fixed 17→32 sign extender. It accepts an IN_W-bit immediate and produces an OUT_W-bit operand in one of four extension modes, and carries a tag for writeback/branch bookkeeping. It sits between decode and execute, with a valid/ready handshake on both sides, DEPTH register stages and a flush input for pipeline squashes.

---
 rtl/imm_ext_pkg.sv | 17 +
 rtl/imm_ext_stage.sv | 30 +++
 rtl/imm_extend_pipe.sv | 70 +++++++
 tb/tb_imm_extend_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: extension mode codes, transfer counter width and the width-generic immediate extension function
package imm_ext_pkg;
  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;
  localparam int CNT_W = 16;
  localparam int EXT_MAX_W = 64;
  function automatic logic [EXT_MAX_W-1:0] ext_fn(input logic [EXT_MAX_W-1:0] data, input logic [1:0] mode,
                                                  input int in_w, input int out_w);
    logic [EXT_MAX_W-1:0] mask, d, sext;
    mask = ~({EXT_MAX_W{1'b1}} << in_w);
    d = data & mask;
    sext = ((d >> (in_w - 1)) != '0) ? (d | ~mask) : d;
    return mode == IMM_SEXT ? sext : mode == IMM_ZEXT ? d : mode == IMM_UPPER ? d << (out_w - in_w) : sext << 2;
  endfunction
endpackage

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: one valid/data/tag pipeline slice (load takes d_*, clear drops valid, rst zeroes everything)
module imm_ext_stage #(
  parameter int DW = 32,
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  input  logic [TW-1:0] d_tag,
  output logic          q_valid,
  output logic [DW-1:0] q_data,
  output logic [TW-1:0] q_tag
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data <= '0;
      q_tag <= '0;
    end else begin
      q_valid <= clear ? 1'b0 : load ? d_valid : q_valid;
      if (load && d_valid) begin
        q_data <= d_data;
        q_tag <= d_tag;
      end
    end
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: DEPTH-stage valid/ready immediate extender (in_* -> mode mux -> stages -> out_*, flush squash, xfer_count only with IMMEXT_CNT_EN)
module imm_extend_pipe import imm_ext_pkg::*; #(
  parameter int IN_W = 17,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg
`ifdef IMMEXT_CNT_EN
  ,output logic [CNT_W-1:0] xfer_count
`endif
);
  if (IN_W < 2 || OUT_W < IN_W + 2 || OUT_W > EXT_MAX_W || DEPTH < 1 || DEPTH > 4) begin : g_bad_params
    $error("imm_extend_pipe: illegal IN_W/OUT_W/DEPTH");
  end
  logic [DEPTH-1:0] v, en, vin;
  logic [OUT_W-1:0] dq [DEPTH];
  logic [OUT_W-1:0] din [DEPTH];
  logic [TAG_W-1:0] tq [DEPTH];
  logic [TAG_W-1:0] tin [DEPTH];
  always_comb begin
    en[DEPTH-1] = !v[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) en[k] = !v[k] || en[k+1];
    in_ready = !reset && !flush && en[0];
    vin[0] = in_valid && in_ready;
    din[0] = OUT_W'(ext_fn(EXT_MAX_W'(in_data), in_mode, IN_W, OUT_W));
    tin[0] = in_tag;
    for (int k = 1; k < DEPTH; k++) begin
      vin[k] = v[k-1];
      din[k] = dq[k-1];
      tin[k] = tq[k-1];
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    imm_ext_stage #(.DW(OUT_W), .TW(TAG_W)) u_stage (
      .clk(clock),
      .rst(reset),
      .clear(flush),
      .load(en[k]),
      .d_valid(vin[k]),
      .d_data(din[k]),
      .d_tag(tin[k]),
      .q_valid(v[k]),
      .q_data(dq[k]),
      .q_tag(tq[k])
    );
  end
  assign out_valid = v[DEPTH-1];
  assign out_data = dq[DEPTH-1];
  assign out_tag = tq[DEPTH-1];
  assign out_neg = dq[DEPTH-1][OUT_W-1];
`ifdef IMMEXT_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) xfer_count <= '0;
    else if (out_valid && out_ready && xfer_count != '1) xfer_count <= xfer_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe (IN_W=17, OUT_W=32, DEPTH=2), counter checks with IMMEXT_CNT_EN
module tb_imm_extend_pipe;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [16:0] in_data = '0;
  logic [1:0] in_mode = '0;
  logic [4:0] in_tag = '0;
  logic in_ready, out_valid, out_neg;
  logic [31:0] out_data;
  logic [4:0] out_tag;
`ifdef IMMEXT_CNT_EN
  logic [15:0] xfer_count;
`endif
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  logic [36:0] sbq [$];
  imm_extend_pipe #(.IN_W(17), .OUT_W(32), .DEPTH(2), .TAG_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mode(in_mode),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_neg(out_neg)
`ifdef IMMEXT_CNT_EN
    ,.xfer_count(xfer_count)
`endif
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic logic [36:0] model(input logic [16:0] d, input logic [1:0] m, input logic [4:0] t);
    logic [31:0] s, r;
    s = {{15{d[16]}}, d};
    case (m)
      2'd0: r = s;
      2'd1: r = {15'b0, d};
      2'd2: r = {d, 15'b0};
      default: r = {s[29:0], 2'b00};
    endcase
    return {t, r};
  endfunction
  always @(negedge clock) begin
    logic [36:0] e;
    if (reset) begin
      sbq.delete();
      xfers = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) check("sb_pop_empty", 64'(sbq.size()), 64'd1);
        else begin
          e = sbq.pop_front();
          check("sb_data", 64'(out_data), 64'(e[31:0]));
          check("sb_tag", 64'(out_tag), 64'(e[36:32]));
          check("sb_neg", 64'(out_neg), 64'(e[31]));
        end
        if (xfers != 16'hFFFF) xfers++;
      end
      if (flush) sbq.delete();
      if (in_valid && in_ready) sbq.push_back(model(in_data, in_mode, in_tag));
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [16:0] d, input logic [1:0] m, input logic [4:0] t);
    in_valid = 1'b1;
    in_data = d;
    in_mode = m;
    in_tag = t;
  endtask
  task automatic offer(input int i);
    in_valid = i < 5;
    in_data = 17'h1000 + 17'(i * 819);
    in_mode = 2'(i);
    in_tag = 5'(8 + i);
  endtask
  initial begin
    int idx, got;
    logic a;
    logic [36:0] ez;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_neg", 64'(out_neg), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef IMMEXT_CNT_EN
    check("rst_cnt", 64'(xfer_count), 64'd0);
`endif
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    drive(17'h10000, 2'd0, 5'd3);
    tick();
    in_valid = 1'b0;
    check("sext_latency", 64'(out_valid), 64'd0);
    tick();
    check("sext_valid", 64'(out_valid), 64'd1);
    check("sext_data", 64'(out_data), 64'hFFFF0000);
    check("sext_tag", 64'(out_tag), 64'd3);
    check("sext_neg", 64'(out_neg), 64'd1);
    drive(17'h0FFFF, 2'd0, 5'd4);
    tick();
    in_valid = 1'b0;
    tick();
    check("sext_pos_data", 64'(out_data), 64'h0000FFFF);
    check("sext_pos_neg", 64'(out_neg), 64'd0);
    drive(17'h1FFFF, 2'd1, 5'd5);
    tick();
    drive(17'h00005, 2'd2, 5'd6);
    tick();
    check("zext_valid", 64'(out_valid), 64'd1);
    check("zext_data", 64'(out_data), 64'h0001FFFF);
    drive(17'h1FFFF, 2'd3, 5'd7);
    tick();
    check("upper_valid", 64'(out_valid), 64'd1);
    check("upper_data", 64'(out_data), 64'h00028000);
    in_valid = 1'b0;
    tick();
    check("branch_valid", 64'(out_valid), 64'd1);
    check("branch_data", 64'(out_data), 64'hFFFFFFFC);
    tick();
    check("b2b_drained", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      offer(idx);
      #1;
      a = in_ready;
      tick();
      if (a) idx++;
    end
    check("bp_accepts", 64'(idx), 64'd2);
    offer(idx);
    #1;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_ready_return", 64'(in_ready), 64'd1);
    got = 0;
    for (int c = 0; c < 12 && got < 5; c++) begin
      offer(idx);
      #1;
      a = in_ready;
      check("bp_nogap", 64'(out_valid), 64'd1);
      got += int'(out_valid);
      tick();
      if (a) idx++;
    end
    check("bp_count", 64'(got), 64'd5);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);
    drive(17'h00123, 2'd0, 5'd20);
    tick();
    drive(17'h00456, 2'd1, 5'd21);
    tick();
    drive(17'h00789, 2'd2, 5'd22);
    ez = model(17'h00789, 2'd2, 5'd22);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    #1;
    check("flush_after_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("flush_next_lat", 64'(out_valid), 64'd0);
    tick();
    check("flush_next_valid", 64'(out_valid), 64'd1);
    check("flush_next_tag", 64'(out_tag), 64'd22);
    check("flush_next_data", 64'(out_data), 64'(ez[31:0]));
    tick();
    out_ready = 1'b0;
    drive(17'h1ABCD, 2'd0, 5'd31);
    tick();
    drive(17'h0BCDE, 2'd1, 5'd30);
    tick();
    in_valid = 1'b0;
    check("mid_full", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    check("mid_rst_tag", 64'(out_tag), 64'd0);
    check("mid_rst_neg", 64'(out_neg), 64'd0);
`ifdef IMMEXT_CNT_EN
    check("mid_rst_cnt", 64'(xfer_count), 64'd0);
`endif
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_data = 17'($urandom);
      in_mode = 2'($urandom);
      in_tag = 5'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 50) == 0;
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    check("sb_drain", 64'(sbq.size()), 64'd0);
`ifdef IMMEXT_CNT_EN
    check("cnt_model", 64'(xfer_count), 64'(xfers));
    for (int c = 0; c < 70000; c++) begin
      drive(17'($urandom), 2'($urandom), 5'($urandom));
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("cnt_sat", 64'(xfer_count), 64'hFFFF);
    check("cnt_model_sat", 64'(xfer_count), 64'(xfers));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cnt_flush_hold", 64'(xfer_count), 64'hFFFF);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
